rv32i_id_stage: RTL and testbench
=================================

RV32I_ID_STAGE -- requirements
Module: rv32i_id_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc and immediate; values other than 32 are out of scope.
REQ-002 Parameter RF_ADDR_W, default 5, register address width; 4 selects RV32E.
REQ-003 Parameter LOAD_USE_STALL, default 1, enables load-use bubble insertion.
REQ-004 The clock is clk, a single clock domain.
REQ-005 The reset is rst_n, asynchronous and active-low.
REQ-006 Port clk  in  1  rising-edge clock.
REQ-007 Port rst_n  in  1  asynchronous active-low reset.
REQ-008 Port in_valid  in  1  upstream (IF/ID) instruction valid.
REQ-009 Port in_ready  out  1  stage accepts an instruction this cycle.
REQ-010 Port in_instr  in  32  raw instruction.
REQ-011 Port in_pc  in  XLEN  instruction address.
REQ-012 Port flush  in  1  discard held and incoming instruction.
REQ-013 Port out_valid  out  1  ID/EX register holds a decoded instruction.
REQ-014 Port out_ready  in  1  downstream (EX) accepts.
REQ-015 Port out_rs1, out_rs2, out_rd  out  RF_ADDR_W each  register addresses.
REQ-016 Port out_imm  out  XLEN  sign-extended immediate.
REQ-017 Port out_pc  out  XLEN  registered in_pc.
REQ-018 Port out_we, out_is_load, out_illegal  out  1 each  rd write enable, load flag, illegal flag.
REQ-019 Port stall_cnt  out  16  saturating count of load-use bubble cycles.

Function
REQ-020 Decode: R (0110011) rs1, rs2, rd; I-ALU (0010011), load (0000011) and JALR (1100111) rs1, rs2=0, rd; S (0100011) and B (1100011) rs1, rs2, rd=0; LUI (0110111), AUIPC (0010111), JAL (1101111) rs1=rs2=0, rd.
REQ-021 Immediates: I, S, B, U and J formats sign-extended to XLEN; R-type imm=0.
REQ-022 out_we=1 only when the format writes rd and rd!=0.
REQ-023 out_is_load=1 only for opcode 0000011.
REQ-024 Any other opcode sets out_illegal=1, all addresses 0, we=0, imm=0.
REQ-025 RF_ADDR_W=4: any used register field with bit 4 set sets out_illegal=1 and forces we=0.
REQ-026 The stage has two states, EMPTY and FULL; all outputs are registered and the decode latency is one cycle from acceptance.
REQ-027 Acceptance: in_valid && in_ready at a rising edge loads the decoded fields and goes to FULL.
REQ-028 Transfer: out_valid && out_ready with no acceptance in the same cycle goes to EMPTY.
REQ-029 Back-to-back: transfer and acceptance in the same cycle stay FULL with the new contents.
REQ-030 in_ready = (EMPTY || out_ready) && !hazard && !flush.
REQ-031 hazard = LOAD_USE_STALL && FULL && out_is_load && out_rd!=0 && in_valid && (out_rd matches a used rs1 or rs2 of in_instr); the load transfers with no acceptance, giving exactly one out_valid=0 bubble cycle, and the dependent is accepted the following cycle.
REQ-032 stall_cnt increments once per cycle in which hazard blocks a transfer-capable cycle and saturates at 0xFFFF.
REQ-033 Output fields hold stable while FULL && !out_ready.
REQ-034 flush has priority over every other event: the next state is EMPTY, out_valid=0, and the incoming instruction is dropped; stall_cnt is unaffected.

Reset
REQ-035 rst_n low asynchronously forces EMPTY, out_valid=0, all out_* fields 0 and stall_cnt=0, including mid-transfer or mid-hazard.
REQ-036 After rst_n deasserts, in_ready follows REQ-030 from the first edge.

Verification
REQ-037 ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, rs1=1, rs2=2, rd=3, we=1, imm=0.
REQ-038 SW x5,-4(x6) (0xFE532E23) -> rs1=6, rs2=5, rd=0, we=0, imm=0xFFFFFFFC.
REQ-039 LW x4,0(x1) (0x0000A203) then ADD x5,x4,x4 (0x004202B3), out_ready=1 -> one bubble cycle between them, in_ready=0 for one cycle, stall_cnt=1; with LOAD_USE_STALL=0 -> no bubble.
REQ-040 FULL, out_ready=0 for 3 cycles -> outputs unchanged, in_ready=0; out_ready=1 with in_valid=1 -> back-to-back replacement.
REQ-041 flush=1 concurrent with in_valid=1 while FULL -> next cycle out_valid=0, the instruction is not decoded.
REQ-042 rst_n pulsed low mid-hazard -> immediately out_valid=0, stall_cnt=0; opcode 0x7F -> out_illegal=1, we=0.

Source files
------------

// File: rtl/rv32i_id_stage_if.sv
// ---------------------------------------------------------------------------
// rv32i_id_stage_if
// Bundles the upstream (IF/ID) and downstream (ID/EX) handshakes of the
// RV32I decode stage, plus its flush input and stall counter.
//   slave  : decode stage side (consumes in_*, produces out_*)
//   master : environment side (fetch, execute, pipeline control)
// Signals:
//   in_valid/in_ready/in_instr/in_pc  upstream instruction handshake
//   flush                             discard held and incoming instruction
//   out_valid/out_ready               downstream handshake
//   out_rs1/out_rs2/out_rd            decoded register addresses
//   out_imm/out_pc                    sign-extended immediate, instruction pc
//   out_we/out_is_load/out_illegal    decoded control flags
//   stall_cnt                         saturating load-use bubble count
// ---------------------------------------------------------------------------
interface rv32i_id_stage_if #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RF_ADDR_W = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_instr;
   logic [XLEN-1:0]      in_pc;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [RF_ADDR_W-1:0] out_rs1;
   logic [RF_ADDR_W-1:0] out_rs2;
   logic [RF_ADDR_W-1:0] out_rd;
   logic [XLEN-1:0]      out_imm;
   logic [XLEN-1:0]      out_pc;
   logic                 out_we;
   logic                 out_is_load;
   logic                 out_illegal;
   logic [15:0]          stall_cnt;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_rs1, out_rs2, out_rd, out_imm, out_pc,
             out_we, out_is_load, out_illegal, stall_cnt
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_rs1, out_rs2, out_rd, out_imm, out_pc,
             out_we, out_is_load, out_illegal, stall_cnt
   );
endinterface

// File: rtl/rv32i_id_stage.sv
// ---------------------------------------------------------------------------
// rv32i_id_stage
// RV32I instruction decode stage with a one-entry ID/EX output register,
// load-use bubble insertion and flush.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rv32i_id_stage_if.slave (handshakes, decoded fields, stall_cnt)
// Parameters:
//   XLEN            datapath width of pc and immediate (32 only)
//   RF_ADDR_W       register address width, 4 selects RV32E
//   LOAD_USE_STALL  insert one bubble between a load and a dependent
// ---------------------------------------------------------------------------
module rv32i_id_stage #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned RF_ADDR_W      = 5,
   parameter bit          LOAD_USE_STALL = 1'b1
) (
   input logic                clk,
   input logic                rst_n,
   rv32i_id_stage_if.slave    bus
);
   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e               r_state;
   logic [RF_ADDR_W-1:0] r_rs1, r_rs2, r_rd;
   logic [XLEN-1:0]      r_imm, r_pc;
   logic                 r_we, r_is_load, r_illegal;
   logic [15:0]          r_stall_cnt;

   logic [6:0]           w_opcode;
   logic                 w_use_rs1, w_use_rs2, w_use_rd;
   logic                 w_legal, w_is_load_raw, w_rve_bad, w_illegal;
   logic [XLEN-1:0]      w_imm_raw;
   logic [RF_ADDR_W-1:0] w_rs1_raw, w_rs2_raw, w_rd_raw;
   logic [RF_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
   logic [XLEN-1:0]      w_imm;
   logic                 w_we, w_is_load;
   logic                 w_hazard, w_in_ready, w_accept, w_transfer;

   assign w_opcode  = bus.in_instr[6:0];
   assign w_rs1_raw = bus.in_instr[15 +: RF_ADDR_W];
   assign w_rs2_raw = bus.in_instr[20 +: RF_ADDR_W];
   assign w_rd_raw  = bus.in_instr[7 +: RF_ADDR_W];

   always_comb begin
      w_use_rs1     = 1'b0;
      w_use_rs2     = 1'b0;
      w_use_rd      = 1'b0;
      w_is_load_raw = 1'b0;
      w_legal       = 1'b1;
      w_imm_raw     = '0;
      case (w_opcode)
         7'b0110011: begin  // R
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_use_rd  = 1'b1;
         end
         7'b0010011, 7'b1100111, 7'b0000011: begin  // I-ALU, JALR, load
            w_use_rs1     = 1'b1;
            w_use_rd      = 1'b1;
            w_is_load_raw = (w_opcode == 7'b0000011);
            w_imm_raw     = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
         end
         7'b0100011: begin  // S
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_imm_raw = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
         end
         7'b1100011: begin  // B
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_imm_raw = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                         bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin  // LUI, AUIPC
            w_use_rd  = 1'b1;
            w_imm_raw = {bus.in_instr[31:12], 12'h000};
         end
         7'b1101111: begin  // JAL
            w_use_rd  = 1'b1;
            w_imm_raw = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                         bus.in_instr[20], bus.in_instr[30:21], 1'b0};
         end
         default: w_legal = 1'b0;
      endcase
   end

   // RV32E only has x0..x15: a used field with bit 4 set names a missing register
   assign w_rve_bad = (RF_ADDR_W < 5) &&
                      ((w_use_rs1 && bus.in_instr[19]) ||
                       (w_use_rs2 && bus.in_instr[24]) ||
                       (w_use_rd  && bus.in_instr[11]));
   assign w_illegal = !w_legal || w_rve_bad;

   // Illegal instructions carry no addresses, immediate or side effects
   assign w_rs1     = (w_use_rs1 && !w_illegal) ? w_rs1_raw : '0;
   assign w_rs2     = (w_use_rs2 && !w_illegal) ? w_rs2_raw : '0;
   assign w_rd      = (w_use_rd  && !w_illegal) ? w_rd_raw  : '0;
   assign w_imm     = w_illegal ? '0 : w_imm_raw;
   assign w_we      = (w_rd != '0);
   assign w_is_load = w_is_load_raw && !w_illegal;

   assign w_hazard = LOAD_USE_STALL && (r_state == StFull) && r_is_load && (r_rd != '0) &&
                     bus.in_valid &&
                     ((w_use_rs1 && (w_rs1_raw == r_rd)) || (w_use_rs2 && (w_rs2_raw == r_rd)));

   assign w_in_ready = ((r_state == StEmpty) || bus.out_ready) && !w_hazard && !bus.flush;
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_transfer = (r_state == StFull) && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StEmpty;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_imm       <= '0;
         r_pc        <= '0;
         r_we        <= 1'b0;
         r_is_load   <= 1'b0;
         r_illegal   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         // Count bubbles only when EX could otherwise have taken a new instruction
         if (w_hazard && bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (bus.flush) begin
            r_state <= StEmpty;
         end else if (w_accept) begin
            r_state   <= StFull;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_imm     <= w_imm;
            r_pc      <= bus.in_pc;
            r_we      <= w_we;
            r_is_load <= w_is_load;
            r_illegal <= w_illegal;
         end else if (w_transfer) begin
            r_state <= StEmpty;
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = (r_state == StFull);
   assign bus.out_rs1     = r_rs1;
   assign bus.out_rs2     = r_rs2;
   assign bus.out_rd      = r_rd;
   assign bus.out_imm     = r_imm;
   assign bus.out_pc      = r_pc;
   assign bus.out_we      = r_we;
   assign bus.out_is_load = r_is_load;
   assign bus.out_illegal = r_illegal;
   assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_rv32i_id_stage.sv
// ---------------------------------------------------------------------------
// tb_rv32i_id_stage
// Directed bench for rv32i_id_stage. Three instances share one stimulus:
// u_dut0 (RV32I, load-use stall), u_dut1 (no stall), u_dut2 (RV32E).
// ---------------------------------------------------------------------------
module tb_rv32i_id_stage;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   rv32i_id_stage_if #(.XLEN(32), .RF_ADDR_W(5)) if0 ();
   rv32i_id_stage_if #(.XLEN(32), .RF_ADDR_W(5)) if1 ();
   rv32i_id_stage_if #(.XLEN(32), .RF_ADDR_W(4)) if2 ();

   assign if1.in_valid  = if0.in_valid;
   assign if1.in_instr  = if0.in_instr;
   assign if1.in_pc     = if0.in_pc;
   assign if1.flush     = if0.flush;
   assign if1.out_ready = if0.out_ready;
   assign if2.in_valid  = if0.in_valid;
   assign if2.in_instr  = if0.in_instr;
   assign if2.in_pc     = if0.in_pc;
   assign if2.flush     = if0.flush;
   assign if2.out_ready = if0.out_ready;

   rv32i_id_stage #(.XLEN(32), .RF_ADDR_W(5), .LOAD_USE_STALL(1'b1)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0)
   );
   rv32i_id_stage #(.XLEN(32), .RF_ADDR_W(5), .LOAD_USE_STALL(1'b0)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );
   rv32i_id_stage #(.XLEN(32), .RF_ADDR_W(4), .LOAD_USE_STALL(1'b1)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      if0.in_valid  = v;
      if0.in_instr  = instr;
      if0.in_pc     = pc;
      if0.out_ready = ordy;
      if0.flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] AddX3   = 32'h002081B3;
   localparam logic [31:0] SwX5    = 32'hFE532E23;
   localparam logic [31:0] LwX4    = 32'h0000A203;
   localparam logic [31:0] AddDep  = 32'h004202B3;
   localparam logic [31:0] AddiX7  = 32'hFFF00393;
   localparam logic [31:0] LuiX8   = 32'h12345437;
   localparam logic [31:0] JalX1   = 32'h008000EF;
   localparam logic [31:0] AddiX16 = 32'h00100813;
   localparam logic [31:0] BadOp   = 32'hFFFFFFFF;

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", if0.out_valid, 0);
      chk("rst_stall", if0.stall_cnt, 0);
      chk("rst_rd", if0.out_rd, 0);
      chk("rst_imm", if0.out_imm, 0);
      chk("rst_we", if0.out_we, 0);

      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      chk("post_rst_in_ready", if0.in_ready, 1);

      // ADD x3,x1,x2
      drive(1'b1, AddX3, 32'h100, 1'b1, 1'b0);
      tick();
      chk("add_valid", if0.out_valid, 1);
      chk("add_rs1", if0.out_rs1, 1);
      chk("add_rs2", if0.out_rs2, 2);
      chk("add_rd", if0.out_rd, 3);
      chk("add_we", if0.out_we, 1);
      chk("add_imm", if0.out_imm, 0);
      chk("add_pc", if0.out_pc, 32'h100);
      chk("add_e_illegal", if2.out_illegal, 0);

      // SW x5,-4(x6) back-to-back
      drive(1'b1, SwX5, 32'h104, 1'b1, 1'b0);
      tick();
      chk("sw_valid", if0.out_valid, 1);
      chk("sw_rs1", if0.out_rs1, 6);
      chk("sw_rs2", if0.out_rs2, 5);
      chk("sw_rd", if0.out_rd, 0);
      chk("sw_we", if0.out_we, 0);
      chk("sw_imm", if0.out_imm, 32'hFFFFFFFC);

      // LW x4,0(x1) then dependent ADD x5,x4,x4
      drive(1'b1, LwX4, 32'h108, 1'b1, 1'b0);
      tick();
      chk("lw_is_load", if0.out_is_load, 1);
      chk("lw_rd", if0.out_rd, 4);
      chk("lw_rs2", if0.out_rs2, 0);
      drive(1'b1, AddDep, 32'h10C, 1'b1, 1'b0);
      #1;
      chk("hz_in_ready", if0.in_ready, 0);
      chk("hz_nostall_in_ready", if1.in_ready, 1);
      chk("hz_e_in_ready", if2.in_ready, 0);
      tick();
      chk("bubble_valid", if0.out_valid, 0);
      chk("bubble_stall", if0.stall_cnt, 1);
      chk("nostall_valid", if1.out_valid, 1);
      chk("nostall_rd", if1.out_rd, 5);
      chk("nostall_stall", if1.stall_cnt, 0);
      #1;
      chk("after_bubble_in_ready", if0.in_ready, 1);
      tick();
      chk("dep_valid", if0.out_valid, 1);
      chk("dep_rd", if0.out_rd, 5);
      chk("dep_rs1", if0.out_rs1, 4);
      chk("dep_rs2", if0.out_rs2, 4);
      chk("dep_stall", if0.stall_cnt, 1);

      // Downstream stall for three cycles, then back-to-back replacement
      drive(1'b1, AddiX7, 32'h110, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_in_ready", if0.in_ready, 0);
         tick();
         chk("hold_valid", if0.out_valid, 1);
         chk("hold_rd", if0.out_rd, 5);
         chk("hold_pc", if0.out_pc, 32'h10C);
      end
      drive(1'b1, AddiX7, 32'h110, 1'b1, 1'b0);
      #1;
      chk("release_in_ready", if0.in_ready, 1);
      tick();
      chk("addi_rd", if0.out_rd, 7);
      chk("addi_imm", if0.out_imm, 32'hFFFFFFFF);
      chk("addi_rs1", if0.out_rs1, 0);
      chk("addi_pc", if0.out_pc, 32'h110);

      // Flush while FULL with a valid incoming instruction
      drive(1'b1, LuiX8, 32'h114, 1'b0, 1'b1);
      #1;
      chk("flush_in_ready", if0.in_ready, 0);
      tick();
      chk("flush_valid", if0.out_valid, 0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("flush_dropped", if0.out_valid, 0);
      chk("flush_stall", if0.stall_cnt, 1);
      drive(1'b1, LuiX8, 32'h114, 1'b1, 1'b0);
      tick();
      chk("lui_valid", if0.out_valid, 1);
      chk("lui_rd", if0.out_rd, 8);
      chk("lui_imm", if0.out_imm, 32'h12345000);

      drive(1'b1, JalX1, 32'h118, 1'b1, 1'b0);
      tick();
      chk("jal_rd", if0.out_rd, 1);
      chk("jal_imm", if0.out_imm, 32'h8);
      chk("jal_rs1", if0.out_rs1, 0);

      drive(1'b1, AddiX16, 32'h11C, 1'b1, 1'b0);
      tick();
      chk("x16_rd", if0.out_rd, 16);
      chk("x16_illegal", if0.out_illegal, 0);
      chk("x16_e_illegal", if2.out_illegal, 1);
      chk("x16_e_we", if2.out_we, 0);

      drive(1'b1, BadOp, 32'h120, 1'b1, 1'b0);
      tick();
      chk("bad_illegal", if0.out_illegal, 1);
      chk("bad_we", if0.out_we, 0);
      chk("bad_rd", if0.out_rd, 0);
      chk("bad_rs1", if0.out_rs1, 0);
      chk("bad_imm", if0.out_imm, 0);

      // Asynchronous reset in the middle of a hazard
      drive(1'b1, LwX4, 32'h124, 1'b1, 1'b0);
      tick();
      drive(1'b1, AddDep, 32'h128, 1'b1, 1'b0);
      #1;
      chk("hz2_in_ready", if0.in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", if0.out_valid, 0);
      chk("arst_stall", if0.stall_cnt, 0);
      chk("arst_rd", if0.out_rd, 0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("arst_after_valid", if0.out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
